mpu_matrix_loader: RTL and testbench

- Upstream feeder for the MPU element-wise operators (opposite, add, scale, ...).
- Accepts a byte stream of signed 8-bit elements over a valid/ready handshake and assembles complete 5x5 matrices into the MPU flattened 200-bit layout.
- Presents each finished matrix on a valid/ready output, ping-pong double-buffered so the next matrix can stream in while the current one is held for the operator.

---
 rtl/mpu_pkg.sv | 19 +
 rtl/mpu_matrix_loader_if.sv | 28 ++
 rtl/mpu_matrix_buffer.sv | 56 +++++
 rtl/mpu_matrix_loader.sv | 103 ++++++++++
 tb/tb_mpu_matrix_loader.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mpu_pkg.sv
// Shared MPU definitions: element/matrix types, geometry constants and the
// flattened-matrix element offset helper.
package mpu_pkg;

    localparam int MPU_ELEM_W   = 8;
    localparam int MPU_DIM      = 5;
    localparam int MPU_ELEMS    = 25;
    localparam int MPU_MATRIX_W = 200;
    localparam int MPU_CNT_W    = 5;

    typedef logic signed [MPU_ELEM_W-1:0] mpu_elem_t;
    typedef logic [MPU_MATRIX_W-1:0]      mpu_matrix_t;

    // Bit offset of element (col,row); elements are stored row-fastest.
    function automatic int unsigned at(input int unsigned col, input int unsigned row);
        return MPU_ELEM_W * (row + MPU_DIM * col);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader_if.sv
// Stream-in / matrix-out bundle of the MPU matrix loader.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits on ready, and ready never depends on valid.
interface mpu_matrix_loader_if;
    import mpu_pkg::*;

    logic                 flush;
    mpu_elem_t            in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    mpu_matrix_t          matrix_a;
    logic                 matrix_valid;
    logic                 matrix_ready;
    logic [MPU_CNT_W-1:0] fill_count;
    logic                 frame_error;

    modport slave (
        input  flush, in_data, in_valid, in_last, matrix_ready,
        output in_ready, matrix_a, matrix_valid, fill_count, frame_error
    );

    modport master (
        output flush, in_data, in_valid, in_last, matrix_ready,
        input  in_ready, matrix_a, matrix_valid, fill_count, frame_error
    );

endinterface

// File: rtl/mpu_matrix_buffer.sv
// One 200-bit matrix buffer with indexed byte write and its full flag.
module mpu_matrix_buffer
    import mpu_pkg::*;
#(
    parameter int ELEM_W  = MPU_ELEM_W,
    parameter int N_ELEMS = MPU_ELEMS,
    parameter int IDX_W   = MPU_CNT_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      flush_i,
    input  logic                      wr_en_i,
    input  logic [IDX_W-1:0]          wr_idx_i,
    input  logic [ELEM_W-1:0]         wr_data_i,
    input  logic                      set_i,
    input  logic                      clear_i,
    output logic [ELEM_W*N_ELEMS-1:0] data_o,
    output logic                      full_o
);

    logic [ELEM_W*N_ELEMS-1:0] data_q, data_d;
    logic                      full_q, full_d;

    always_comb begin
        data_d = data_q;
        if (wr_en_i) begin
            data_d[ELEM_W*int'(wr_idx_i) +: ELEM_W] = wr_data_i;
        end
    end

    // Flush drops the full flag only; stale contents are left in place.
    always_comb begin
        full_d = full_q;
        if (flush_i) begin
            full_d = 1'b0;
        end else if (set_i) begin
            full_d = 1'b1;
        end else if (clear_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/mpu_matrix_loader.sv
// Assembles a signed byte stream into 5x5 matrices, ping-pong buffered so one
// matrix can be held for the operator while the next one streams in.
module mpu_matrix_loader
    import mpu_pkg::*;
#(
    parameter int ELEM_W  = MPU_ELEM_W,
    parameter int N_ELEMS = MPU_ELEMS,
    parameter int CNT_W   = MPU_CNT_W
) (
    input  logic                clock,
    input  logic                reset,
    mpu_matrix_loader_if.slave  bus
);

    logic [1:0]                full;
    logic [ELEM_W*N_ELEMS-1:0] data [2];

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             frame_err_q, frame_err_d;

    logic accept;
    logic last_slot;
    logic complete;
    logic abort;
    logic consume;

    assign bus.in_ready = !full[wr_sel_q];

    assign last_slot = (cnt_q == CNT_W'(N_ELEMS - 1));
    assign accept    = bus.in_valid && bus.in_ready && !bus.flush;
    assign complete  = accept && last_slot;
    assign abort     = accept && bus.in_last && !last_slot;
    // Completion and consume can never hit the same buffer in one cycle:
    // completion needs it empty, consume needs it full.
    assign consume   = full[rd_sel_q] && bus.matrix_ready && !bus.flush;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        mpu_matrix_buffer #(
            .ELEM_W  (ELEM_W),
            .N_ELEMS (N_ELEMS),
            .IDX_W   (CNT_W)
        ) u_buf (
            .clk_i     (clock),
            .rst_i     (reset),
            .flush_i   (bus.flush),
            .wr_en_i   (accept && (wr_sel_q == 1'(b))),
            .wr_idx_i  (cnt_q),
            .wr_data_i (bus.in_data),
            .set_i     (complete && (wr_sel_q == 1'(b))),
            .clear_i   (consume && (rd_sel_q == 1'(b))),
            .data_o    (data[b]),
            .full_o    (full[b])
        );
    end

    always_comb begin
        cnt_d       = cnt_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        frame_err_d = 1'b0;
        if (bus.flush) begin
            cnt_d    = '0;
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
        end else begin
            if (complete) begin
                cnt_d       = '0;
                wr_sel_d    = !wr_sel_q;
                frame_err_d = !bus.in_last;
            end else if (abort) begin
                cnt_d       = '0;
                frame_err_d = 1'b1;
            end else if (accept) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (consume) begin
                rd_sel_d = !rd_sel_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q       <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.matrix_a     = data[rd_sel_q];
    assign bus.matrix_valid = full[rd_sel_q];
    assign bus.fill_count   = cnt_q;
    assign bus.frame_error  = frame_err_q;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed bench for mpu_matrix_loader: streams hand-built frames, checks
// delivered matrices against an expected queue and checks the control outputs.
module tb_mpu_matrix_loader;
    import mpu_pkg::*;

    logic clock;
    logic reset;

    mpu_matrix_loader_if lif ();

    mpu_matrix_loader u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (lif.slave)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;
    int stall_cnt = 0;

    logic [MPU_MATRIX_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [MPU_MATRIX_W-1:0] got,
                         input logic [MPU_MATRIX_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // scoreboard: every consume must match the head of the expected queue
    always @(negedge clock) begin
        if (!reset && !lif.flush && lif.matrix_valid && lif.matrix_ready) begin
            check("sb_nonempty", MPU_MATRIX_W'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                check("sb_matrix", lif.matrix_a, exp_q.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (!reset && lif.frame_error) fe_cnt++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_elem(input logic [7:0] d, input logic l);
        int waits;
        waits = 0;
        lif.in_data  = d;
        lif.in_valid = 1'b1;
        lif.in_last  = l;
        while (!lif.in_ready && waits < 100) begin
            tick();
            waits++;
            stall_cnt++;
        end
        check("ready_timeout", MPU_MATRIX_W'(lif.in_ready), 1);
        tick();
        lif.in_valid = 1'b0;
        lif.in_last  = 1'b0;
    endtask

    initial begin
        logic [MPU_MATRIX_W-1:0] m;
        logic [MPU_MATRIX_W-1:0] m_ff;
        logic [MPU_MATRIX_W-1:0] m_03;
        logic [7:0]              v;
        int                      fe0;
        int                      st0;

        reset            = 1'b1;
        lif.flush        = 1'b0;
        lif.in_data      = '0;
        lif.in_valid     = 1'b0;
        lif.in_last      = 1'b0;
        lif.matrix_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        // reset values
        check("rst_matrix_a", lif.matrix_a, '0);
        check("rst_valid", MPU_MATRIX_W'(lif.matrix_valid), 0);
        check("rst_in_ready", MPU_MATRIX_W'(lif.in_ready), 1);
        check("rst_fill", MPU_MATRIX_W'(lif.fill_count), 0);
        check("rst_ferr", MPU_MATRIX_W'(lif.frame_error), 0);

        // ramp 0..24, consumer always ready
        m = '0;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'(k);
        exp_q.push_back(m);
        lif.matrix_ready = 1'b1;
        for (int k = 0; k < 24; k++) send_elem(8'(k), 1'b0);
        check("ramp_fill24", MPU_MATRIX_W'(lif.fill_count), 24);
        check("ramp_valid_early", MPU_MATRIX_W'(lif.matrix_valid), 0);
        send_elem(8'd24, 1'b1);
        check("ramp_valid", MPU_MATRIX_W'(lif.matrix_valid), 1);
        check("ramp_data", lif.matrix_a, m);
        check("ramp_elem_c2r3", MPU_MATRIX_W'(lif.matrix_a[at(2, 3) +: 8]), 13);
        tick();
        check("ramp_consumed", MPU_MATRIX_W'(lif.matrix_valid), 0);
        check("ramp_no_ferr", MPU_MATRIX_W'(fe_cnt), 0);
        lif.matrix_ready = 1'b0;

        // both buffers full, then single consume
        m_ff = {25{8'hFF}};
        m_03 = {25{8'h03}};
        exp_q.push_back(m_ff);
        exp_q.push_back(m_03);
        for (int k = 0; k < 25; k++) send_elem(8'hFF, k == 24);
        for (int k = 0; k < 25; k++) send_elem(8'h03, k == 24);
        check("full_in_ready", MPU_MATRIX_W'(lif.in_ready), 0);
        check("full_valid", MPU_MATRIX_W'(lif.matrix_valid), 1);
        check("full_hold_ff", lif.matrix_a, m_ff);
        tick();
        check("full_stable_ff", lif.matrix_a, m_ff);
        lif.matrix_ready = 1'b1;
        tick();
        lif.matrix_ready = 1'b0;
        check("full_next_valid", MPU_MATRIX_W'(lif.matrix_valid), 1);
        check("full_next_03", lif.matrix_a, m_03);
        check("full_in_ready_back", MPU_MATRIX_W'(lif.in_ready), 1);
        lif.matrix_ready = 1'b1;
        tick();
        lif.matrix_ready = 1'b0;
        check("full_drained", MPU_MATRIX_W'(lif.matrix_valid), 0);

        // four back-to-back frames with a consumer that is always ready
        lif.matrix_ready = 1'b1;
        st0 = stall_cnt;
        for (int f = 0; f < 4; f++) begin
            m = '0;
            for (int k = 0; k < 25; k++) begin
                v = 8'(30 * f + k + 7);
                m[8*k +: 8] = v;
            end
            exp_q.push_back(m);
            for (int k = 0; k < 25; k++) send_elem(8'(30 * f + k + 7), k == 24);
        end
        tick();
        tick();
        check("b2b_no_stall", MPU_MATRIX_W'(stall_cnt - st0), 0);
        check("b2b_all_out", MPU_MATRIX_W'(exp_q.size()), 0);

        // early in_last on index 10, then a clean frame
        fe0 = fe_cnt;
        for (int k = 0; k < 5; k++) send_elem(8'h40, 1'b0);
        check("early_fill5", MPU_MATRIX_W'(lif.fill_count), 5);
        for (int k = 5; k < 11; k++) send_elem(8'h40, k == 10);
        check("early_ferr", MPU_MATRIX_W'(lif.frame_error), 1);
        check("early_fill0", MPU_MATRIX_W'(lif.fill_count), 0);
        check("early_valid", MPU_MATRIX_W'(lif.matrix_valid), 0);
        tick();
        check("early_ferr_once", MPU_MATRIX_W'(lif.frame_error), 0);
        m = '0;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'(8'hA0 ^ 8'(k));
        exp_q.push_back(m);
        for (int k = 0; k < 25; k++) send_elem(8'(8'hA0 ^ 8'(k)), k == 24);
        tick();
        tick();
        check("early_clean_out", MPU_MATRIX_W'(exp_q.size()), 0);
        check("early_ferr_count", MPU_MATRIX_W'(fe_cnt - fe0), 1);

        // 25 elements with no in_last
        fe0 = fe_cnt;
        m = '0;
        for (int k = 0; k < 25; k++) m[8*k +: 8] = 8'(8'h80 + 8'(k));
        exp_q.push_back(m);
        for (int k = 0; k < 25; k++) send_elem(8'(8'h80 + 8'(k)), 1'b0);
        check("nolast_ferr", MPU_MATRIX_W'(lif.frame_error), 1);
        check("nolast_valid", MPU_MATRIX_W'(lif.matrix_valid), 1);
        tick();
        check("nolast_out", MPU_MATRIX_W'(exp_q.size()), 0);
        check("nolast_ferr_count", MPU_MATRIX_W'(fe_cnt - fe0), 1);

        // flush with one matrix held and a partial of 7
        lif.matrix_ready = 1'b0;
        for (int k = 0; k < 25; k++) send_elem(8'h11, k == 24);
        for (int k = 0; k < 7; k++) send_elem(8'h22, 1'b0);
        check("pre_flush_fill", MPU_MATRIX_W'(lif.fill_count), 7);
        check("pre_flush_valid", MPU_MATRIX_W'(lif.matrix_valid), 1);
        lif.flush    = 1'b1;
        lif.in_valid = 1'b1;
        lif.in_last  = 1'b1;
        lif.in_data  = 8'h55;
        tick();
        lif.flush    = 1'b0;
        lif.in_valid = 1'b0;
        lif.in_last  = 1'b0;
        check("flush_valid", MPU_MATRIX_W'(lif.matrix_valid), 0);
        check("flush_in_ready", MPU_MATRIX_W'(lif.in_ready), 1);
        check("flush_fill", MPU_MATRIX_W'(lif.fill_count), 0);
        check("flush_ferr", MPU_MATRIX_W'(lif.frame_error), 0);

        // reset mid-frame
        for (int k = 0; k < 7; k++) send_elem(8'h33, 1'b0);
        check("pre_rst_fill", MPU_MATRIX_W'(lif.fill_count), 7);
        fe0 = fe_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_matrix_a", lif.matrix_a, '0);
        check("mid_rst_valid", MPU_MATRIX_W'(lif.matrix_valid), 0);
        check("mid_rst_in_ready", MPU_MATRIX_W'(lif.in_ready), 1);
        check("mid_rst_fill", MPU_MATRIX_W'(lif.fill_count), 0);
        tick();
        check("mid_rst_no_ferr", MPU_MATRIX_W'(fe_cnt - fe0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
